// File: rtl/am_query_scheduler.sv
// Round-robin scheduler sharing one associative memory between NUM_REQ query sources.
// One query in flight; a watchdog aborts queries whose result never arrives.
module am_query_scheduler #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned HV_DIMENSION   = 2000,
    parameter int unsigned LABEL_WIDTH    = 1,
    parameter int unsigned DISTANCE_WIDTH = 11,
    parameter int unsigned MAX_LATENCY    = 64,
    parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                            Clk_CI,
    input  logic                            Reset_RI,
    input  logic [NUM_REQ-1:0]              ReqValid_SI,
    output logic [NUM_REQ-1:0]              ReqReady_SO,
    input  logic [NUM_REQ*HV_DIMENSION-1:0] ReqHypervector_DI,
    output logic                            AmValid_SO,
    input  logic                            AmReady_SI,
    output logic [HV_DIMENSION-1:0]         AmHypervector_DO,
    input  logic                            AmValid_SI,
    output logic                            AmReady_SO,
    input  logic [LABEL_WIDTH-1:0]          AmLabelA_DI,
    input  logic [LABEL_WIDTH-1:0]          AmLabelV_DI,
    input  logic [DISTANCE_WIDTH-1:0]       AmDistA_DI,
    input  logic [DISTANCE_WIDTH-1:0]       AmDistV_DI,
    output logic                            RespValid_SO,
    input  logic                            RespReady_SI,
    output logic [ID_WIDTH-1:0]             RespId_DO,
    output logic [LABEL_WIDTH-1:0]          RespLabelA_DO,
    output logic [LABEL_WIDTH-1:0]          RespLabelV_DO,
    output logic [DISTANCE_WIDTH-1:0]       RespDistA_DO,
    output logic [DISTANCE_WIDTH-1:0]       RespDistV_DO,
    output logic                            Timeout_SO
);

    localparam int unsigned         WD_WIDTH = $clog2(MAX_LATENCY);
    localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(MAX_LATENCY - 1);
    localparam logic [ID_WIDTH-1:0] ID_LAST  = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitResult,
        StDeliver
    } state_e;

    state_e                    state_q;
    logic [HV_DIMENSION-1:0]   query_q;
    logic [ID_WIDTH-1:0]       id_q;
    logic [ID_WIDTH-1:0]       last_grant_q;
    logic [WD_WIDTH-1:0]       watchdog_q;
    logic [LABEL_WIDTH-1:0]    label_a_q;
    logic [LABEL_WIDTH-1:0]    label_v_q;
    logic [DISTANCE_WIDTH-1:0] dist_a_q;
    logic [DISTANCE_WIDTH-1:0] dist_v_q;
    logic                      am_valid_q;
    logic                      am_ready_q;
    logic                      resp_valid_q;
    logic                      timeout_q;

    logic [2*NUM_REQ-1:0]      valid_twice;
    logic [NUM_REQ-1:0]        valid_rot;
    logic                      grant_found;
    logic [ID_WIDTH-1:0]       grant_id;
    logic [NUM_REQ-1:0]        grant_oh;
    logic [HV_DIMENSION-1:0]   grant_hv;

    // Rotate the request vector so bit 0 is the requester right after the last grant.
    always_comb begin
        valid_twice = {ReqValid_SI, ReqValid_SI};
        valid_rot   = NUM_REQ'(valid_twice >> (32'(last_grant_q) + 32'd1));
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && valid_rot[j]) begin
                grant_found = 1'b1;
                grant_id    = ID_WIDTH'((32'(last_grant_q) + 32'd1 + j) % NUM_REQ);
            end
        end
        grant_oh = '0;
        grant_hv = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_found && (grant_id == ID_WIDTH'(i))) begin
                grant_oh[i] = 1'b1;
                grant_hv    = ReqHypervector_DI[i*HV_DIMENSION +: HV_DIMENSION];
            end
        end
    end

    assign ReqReady_SO = (state_q == StIdle) ? grant_oh : '0;

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q      <= StIdle;
            query_q      <= '0;
            id_q         <= '0;
            last_grant_q <= ID_LAST;
            watchdog_q   <= '0;
            label_a_q    <= '0;
            label_v_q    <= '0;
            dist_a_q     <= '0;
            dist_v_q     <= '0;
            am_valid_q   <= 1'b0;
            am_ready_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        query_q      <= grant_hv;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        am_valid_q   <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    if (AmReady_SI) begin
                        am_valid_q <= 1'b0;
                        am_ready_q <= 1'b1;
                        watchdog_q <= '0;
                        state_q    <= StWaitResult;
                    end
                end
                StWaitResult: begin
                    // A result arriving on the last watchdog cycle still wins.
                    if (AmValid_SI) begin
                        label_a_q    <= AmLabelA_DI;
                        label_v_q    <= AmLabelV_DI;
                        dist_a_q     <= AmDistA_DI;
                        dist_v_q     <= AmDistV_DI;
                        am_ready_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= StDeliver;
                    end else if (watchdog_q == WD_LAST) begin
                        am_ready_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        watchdog_q <= watchdog_q + 1'b1;
                    end
                end
                StDeliver: begin
                    if (RespReady_SI) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign AmValid_SO       = am_valid_q;
    assign AmHypervector_DO = query_q;
    assign AmReady_SO       = am_ready_q;
    assign RespValid_SO     = resp_valid_q;
    assign RespId_DO        = id_q;
    assign RespLabelA_DO    = label_a_q;
    assign RespLabelV_DO    = label_v_q;
    assign RespDistA_DO     = dist_a_q;
    assign RespDistV_DO     = dist_v_q;
    assign Timeout_SO       = timeout_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
// Bench for am_query_scheduler: table-driven transactions, directed corner cases and random
// traffic, all checked cycle by cycle against a transaction-level protocol model.
module tb_am_query_scheduler;

    localparam int NR = 3;
    localparam int HV = 32;
    localparam int LW = 1;
    localparam int DW = 11;
    localparam int ML = 32;
    localparam int IW = 2;

    logic             clk;
    logic             Reset_RI;
    logic [NR-1:0]    ReqValid_SI;
    logic [NR-1:0]    ReqReady_SO;
    logic [NR*HV-1:0] ReqHypervector_DI;
    logic             AmValid_SO;
    logic             AmReady_SI;
    logic [HV-1:0]    AmHypervector_DO;
    logic             AmValid_SI;
    logic             AmReady_SO;
    logic [LW-1:0]    AmLabelA_DI, AmLabelV_DI;
    logic [DW-1:0]    AmDistA_DI, AmDistV_DI;
    logic             RespValid_SO;
    logic             RespReady_SI;
    logic [IW-1:0]    RespId_DO;
    logic [LW-1:0]    RespLabelA_DO, RespLabelV_DO;
    logic [DW-1:0]    RespDistA_DO, RespDistV_DO;
    logic             Timeout_SO;

    am_query_scheduler #(
        .NUM_REQ       (NR),
        .HV_DIMENSION  (HV),
        .LABEL_WIDTH   (LW),
        .DISTANCE_WIDTH(DW),
        .MAX_LATENCY   (ML),
        .ID_WIDTH      (IW)
    ) dut (
        .Clk_CI           (clk),
        .Reset_RI         (Reset_RI),
        .ReqValid_SI      (ReqValid_SI),
        .ReqReady_SO      (ReqReady_SO),
        .ReqHypervector_DI(ReqHypervector_DI),
        .AmValid_SO       (AmValid_SO),
        .AmReady_SI       (AmReady_SI),
        .AmHypervector_DO (AmHypervector_DO),
        .AmValid_SI       (AmValid_SI),
        .AmReady_SO       (AmReady_SO),
        .AmLabelA_DI      (AmLabelA_DI),
        .AmLabelV_DI      (AmLabelV_DI),
        .AmDistA_DI       (AmDistA_DI),
        .AmDistV_DI       (AmDistV_DI),
        .RespValid_SO     (RespValid_SO),
        .RespReady_SI     (RespReady_SI),
        .RespId_DO        (RespId_DO),
        .RespLabelA_DO    (RespLabelA_DO),
        .RespLabelV_DO    (RespLabelV_DO),
        .RespDistA_DO     (RespDistA_DO),
        .RespDistV_DO     (RespDistV_DO),
        .Timeout_SO       (Timeout_SO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AM behavioural model ----------------
    int            am_lat = 0;   // -1 means never respond
    int            am_acc = 0;
    bit            am_rand = 0;
    logic [LW-1:0] cfg_la, cfg_lv;
    logic [DW-1:0] cfg_da, cfg_dv;
    int            am_st = 0;
    int            am_cnt = 0;

    initial begin
        AmReady_SI = 1'b0; AmValid_SI = 1'b0;
        AmLabelA_DI = '0; AmLabelV_DI = '0; AmDistA_DI = '0; AmDistV_DI = '0;
        forever begin
            @(posedge clk); #2;
            if (Reset_RI) begin
                am_st = 0; am_cnt = 0; AmReady_SI = 1'b0; AmValid_SI = 1'b0;
            end else begin
                case (am_st)
                    0: if (AmValid_SO) begin
                        if (am_cnt >= am_acc) begin
                            AmReady_SI = 1'b1; am_st = 1; am_cnt = 0;
                        end else am_cnt++;
                    end
                    1: begin
                        AmReady_SI = 1'b0; am_st = 2; am_cnt = 0;
                        if (am_rand)
                            am_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, ML - 1));
                    end
                    2: begin
                        if (!AmReady_SO) begin
                            am_st = 0; am_cnt = 0;
                            if (am_rand) am_acc = $urandom_range(0, 3);
                        end else if (am_lat >= 0 && am_cnt == am_lat) begin
                            AmValid_SI = 1'b1;
                            if (am_rand) begin
                                AmLabelA_DI = LW'($urandom); AmLabelV_DI = LW'($urandom);
                                AmDistA_DI  = DW'($urandom); AmDistV_DI  = DW'($urandom);
                            end else begin
                                AmLabelA_DI = cfg_la; AmLabelV_DI = cfg_lv;
                                AmDistA_DI  = cfg_da; AmDistV_DI  = cfg_dv;
                            end
                            am_st = 3;
                        end else begin
                            am_cnt++;
                            if (am_rand) AmDistA_DI = DW'($urandom);
                        end
                    end
                    default: begin
                        // Scramble the data bus so a non-registered response path shows up.
                        AmValid_SI = 1'b0; am_st = 0; am_cnt = 0;
                        AmLabelA_DI = ~AmLabelA_DI; AmDistA_DI = ~AmDistA_DI;
                        AmLabelV_DI = ~AmLabelV_DI; AmDistV_DI = ~AmDistV_DI;
                        if (am_rand) am_acc = $urandom_range(0, 3);
                    end
                endcase
            end
        end
    end

    // ---------------- requesters and response consumer ----------------
    int            req_left[NR];
    int            req_gap[NR];
    int            gap_cnt[NR];
    bit            hv_ones = 0;
    bit            rand_gap = 0;
    logic [NR-1:0] acc_mask = '0;
    int            stall_left = 0;
    bit            rand_ready = 0;

    initial begin
        ReqValid_SI = '0; ReqHypervector_DI = '0;
        for (int i = 0; i < NR; i++) begin req_left[i] = 0; req_gap[i] = 0; gap_cnt[i] = 0; end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (acc_mask[i]) begin
                    ReqValid_SI[i] = 1'b0;
                    req_left[i]--;
                    gap_cnt[i] = rand_gap ? int'($urandom_range(0, 5)) : req_gap[i];
                end
                if (!ReqValid_SI[i] && req_left[i] > 0) begin
                    if (gap_cnt[i] == 0) begin
                        ReqValid_SI[i] = 1'b1;
                        ReqHypervector_DI[i*HV +: HV] = hv_ones ? {HV{1'b1}} : HV'($urandom);
                    end else gap_cnt[i]--;
                end
            end
        end
    end

    initial begin
        RespReady_SI = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rand_ready) RespReady_SI = ($urandom_range(0, 3) != 0);
            else if (RespValid_SO && stall_left > 0) begin
                stall_left--; RespReady_SI = 1'b0;
            end else RespReady_SI = 1'b1;
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct { int id; logic [23:0] data; } resp_t;

    int            m_phase = 0;  // 0 free, 1 query offered, 2 awaiting result, 3 result held
    int            m_last = NR - 1;
    int            m_id = 0;
    int            m_wcnt = 0;
    int            m_dcyc = 0;
    int            g = 0;
    logic [HV-1:0] m_hv = '0;
    logic [23:0]   m_data = '0;
    bit            m_to_due = 0;
    bit            m_after_rst = 0;
    int            n_timeouts = 0;
    int            grants[$];
    resp_t         resps[$];
    int            dcycs[$];

    function automatic int rr_pick(input int last, input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int oh_index(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (Reset_RI) begin
            m_phase = 0; m_last = NR - 1; m_to_due = 0; m_after_rst = 1; acc_mask = '0;
        end else begin
            acc_mask = ReqValid_SI & ReqReady_SO;
            if (ReqReady_SO != '0) grants.push_back(oh_index(ReqReady_SO));
            if (m_after_rst) begin
                chk("rst_am_hv", AmHypervector_DO, '0);
                chk("rst_resp_id", RespId_DO, '0);
                chk("rst_resp_data", {RespLabelA_DO, RespDistA_DO, RespLabelV_DO, RespDistV_DO}, '0);
                m_after_rst = 0;
            end
            chk("timeout_pulse", Timeout_SO, m_to_due);
            m_to_due = 0;
            chk("am_valid", AmValid_SO, m_phase == 1);
            chk("am_ready", AmReady_SO, m_phase == 2);
            chk("resp_valid", RespValid_SO, m_phase == 3);
            if (m_phase == 0) begin
                g = rr_pick(m_last, ReqValid_SI);
                chk("grant", ReqReady_SO, (g < 0) ? 0 : (1 << g));
                if (g >= 0) begin
                    m_last = g; m_id = g; m_phase = 1;
                    m_hv = HV'(ReqHypervector_DI >> (g * HV));
                end
            end else begin
                chk("req_ready_busy", ReqReady_SO, '0);
                case (m_phase)
                    1: begin
                        chk("am_hv", AmHypervector_DO, m_hv);
                        if (AmReady_SI) begin m_phase = 2; m_wcnt = 0; end
                    end
                    2: begin
                        if (AmValid_SI) begin
                            m_data = {AmLabelA_DI, AmDistA_DI, AmLabelV_DI, AmDistV_DI};
                            m_phase = 3; m_dcyc = 0;
                        end else if (m_wcnt == ML - 1) begin
                            m_to_due = 1; m_phase = 0; n_timeouts++;
                        end else m_wcnt++;
                    end
                    default: begin
                        chk("resp_id", RespId_DO, m_id);
                        chk("resp_data", {RespLabelA_DO, RespDistA_DO, RespLabelV_DO, RespDistV_DO},
                            m_data);
                        m_dcyc++;
                        if (RespReady_SI) begin
                            resps.push_back('{m_id, m_data});
                            dcycs.push_back(m_dcyc);
                            m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- test helpers ----------------
    function automatic bit quiet();
        for (int i = 0; i < NR; i++) if (req_left[i] != 0) return 0;
        return (ReqValid_SI == '0) && (m_phase == 0);
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        @(posedge clk); #3;
        while (n < budget && !quiet()) begin
            @(posedge clk); #3;
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 Reset_RI = 1'b1;
        @(posedge clk); #1 Reset_RI = 1'b0;
    endtask

    task automatic clear_logs();
        grants.delete(); resps.delete(); dcycs.delete();
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        bit            ones;
        int            lat;
        logic [LW-1:0] la;
        logic [DW-1:0] da;
        logic [LW-1:0] lv;
        logic [DW-1:0] dv;
        int            first_id;
    } vec_t;

    vec_t vt[6];
    int   exp_seq[6];
    int   tmo0;

    initial begin
        Reset_RI = 1'b1;
        // Expected first grant assumes the vectors run in order straight after reset.
        vt[0] = '{3'b010, 1, 20, 1'b1, 11'd37,   1'b0, 11'd512,  1};
        vt[1] = '{3'b101, 0, 3,  1'b0, 11'd1,    1'b1, 11'd2047, 2};
        vt[2] = '{3'b011, 0, 0,  1'b1, 11'd0,    1'b1, 11'd0,    1};
        vt[3] = '{3'b111, 0, 5,  1'b1, 11'd1024, 1'b0, 11'd7,    1};
        vt[4] = '{3'b100, 0, 1,  1'b0, 11'd100,  1'b1, 11'd200,  2};
        vt[5] = '{3'b001, 0, 2,  1'b1, 11'd2046, 1'b1, 11'd1,    0};
        repeat (3) @(posedge clk);
        #1 Reset_RI = 1'b0;

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            clear_logs();
            am_lat = vt[v].lat; am_acc = v % 2;
            cfg_la = vt[v].la; cfg_da = vt[v].da; cfg_lv = vt[v].lv; cfg_dv = vt[v].dv;
            hv_ones = vt[v].ones;
            for (int i = 0; i < NR; i++) req_left[i] = int'(vt[v].mask[i]);
            wait_quiet("vec_quiesce", 500);
            chk("vec_ngrants", grants.size(), $countones(vt[v].mask));
            chk("vec_nresps", resps.size(), $countones(vt[v].mask));
            if (grants.size() > 0) chk("vec_first_grant", grants[0], vt[v].first_id);
            if (resps.size() > 0) begin
                chk("vec_first_id", resps[0].id, vt[v].first_id);
                chk("vec_first_data", resps[0].data, {vt[v].la, vt[v].da, vt[v].lv, vt[v].dv});
            end
        end
        hv_ones = 0;

        // All three requesters continuously valid from reset.
        do_reset();
        @(negedge clk);
        clear_logs(); am_lat = 2; am_acc = 0;
        exp_seq = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < NR; i++) begin req_left[i] = 2; req_gap[i] = 0; end
        wait_quiet("rr3_quiesce", 500);
        chk("rr3_ngrants", grants.size(), 6);
        chk("rr3_nresps", resps.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size()) chk("rr3_grant", grants[k], exp_seq[k]);
            if (k < resps.size()) chk("rr3_resp_id", resps[k].id, exp_seq[k]);
        end

        // Requester 0 re-asserts immediately; requester 2 must still be served in turn.
        @(negedge clk);
        clear_logs();
        exp_seq = '{0, 2, 0, 2, 0, 0};
        req_left[0] = 4; req_left[2] = 2;
        wait_quiet("fair_quiesce", 500);
        chk("fair_ngrants", grants.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < grants.size()) chk("fair_grant", grants[k], exp_seq[k]);

        // Response back-pressure for 10 cycles.
        @(negedge clk);
        clear_logs(); am_lat = 4; stall_left = 10;
        req_left[1] = 2;
        wait_quiet("stall_quiesce", 500);
        chk("stall_nresps", dcycs.size(), 2);
        if (dcycs.size() == 2) begin
            chk("stall_deliver_cycles", dcycs[0], 11);
            chk("nostall_deliver_cycles", dcycs[1], 1);
        end

        // AM never answers: watchdog abort, then a result on the last permitted cycle.
        @(negedge clk);
        clear_logs(); am_lat = -1; tmo0 = n_timeouts;
        req_left[0] = 1;
        wait_quiet("tmo_quiesce", 500);
        chk("tmo_count", n_timeouts - tmo0, 1);
        chk("tmo_no_resp", resps.size(), 0);
        @(negedge clk);
        clear_logs(); am_lat = ML - 2; tmo0 = n_timeouts;
        cfg_la = 1'b1; cfg_da = 11'd5; cfg_lv = 1'b0; cfg_dv = 11'd6;
        req_left[2] = 1;
        wait_quiet("late_quiesce", 500);
        chk("late_no_tmo", n_timeouts - tmo0, 0);
        chk("late_nresps", resps.size(), 1);
        if (resps.size() > 0) chk("late_data", resps[0].data, {1'b1, 11'd5, 1'b0, 11'd6});
        // A waiting requester is granted in the timeout cycle itself.
        @(negedge clk);
        clear_logs(); am_lat = -1; tmo0 = n_timeouts;
        req_left[0] = 1; req_left[1] = 1;
        wait_quiet("tmo2_quiesce", 500);
        chk("tmo2_count", n_timeouts - tmo0, 2);
        chk("tmo2_ngrants", grants.size(), 2);
        if (grants.size() == 2) chk("tmo2_second_grant", grants[1], 1);

        // Reset while waiting for a result.
        @(negedge clk);
        clear_logs(); am_lat = -1;
        req_left[1] = 1;
        for (int n = 0; n < 50 && m_phase != 2; n++) @(negedge clk);
        chk("rst_reached_wait", m_phase, 2);
        repeat (3) @(posedge clk);
        #1 Reset_RI = 1'b1;
        req_left[0] = 1; req_left[2] = 1;
        @(posedge clk);
        #1 Reset_RI = 1'b0;
        am_lat = 3;
        clear_logs();
        wait_quiet("rst_quiesce", 500);
        chk("rst_ngrants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("rst_first_grant", grants[0], 0);
            chk("rst_second_grant", grants[1], 2);
        end
        chk("rst_nresps", resps.size(), 2);

        // Random traffic against the model.
        am_rand = 1; rand_gap = 1; rand_ready = 1;
        for (int r = 0; r < 30; r++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) req_left[i] = $urandom_range(0, 3);
            wait_quiet("rand_quiesce", 3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
